// File: rtl/ddr_axi_pkg.sv
// rtl/ddr_axi_pkg.sv - shared DDR AXI constants, widths and read-master state encoding
package ddr_axi_pkg;

    localparam int ADDR_W = 30;
    localparam int LEN_W  = 8;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    // One-hot so each output decodes from a single state bit, as in the arbiter
    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_ADDR = 4'b0010,
        ST_DATA = 4'b0100,
        ST_DONE = 4'b1000
    } rd_state_e;

endpackage

// File: rtl/axi_master_rd_if.sv
// rtl/axi_master_rd_if.sv - AXI4 AR/R channel bundle between read master and DDR MIG
interface axi_master_rd_if
    import ddr_axi_pkg::*;
#(
    parameter int AXI_WIDTH = 64
);
    logic [3:0]           arid;
    logic [ADDR_W-1:0]    araddr;
    logic [LEN_W-1:0]     arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arvalid;
    logic                 arready;
    logic [AXI_WIDTH-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arvalid, rready,
        input  arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
        output arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_master_rd.sv
// rtl/axi_master_rd.sv - single-burst AXI4 read master feeding the granted DDR read channel
module axi_master_rd
    import ddr_axi_pkg::*;
#(
    parameter int         AXI_WIDTH = 64,
    parameter logic [3:0] AXI_ID    = 4'b0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rd_start,
    input  logic [ADDR_W-1:0]    rd_addr,
    input  logic [LEN_W-1:0]     rd_len,
    output logic                 rd_busy,
    output logic                 rd_done,
    output logic                 rd_err,
    output logic [AXI_WIDTH-1:0] rd_data,
    output logic                 rd_data_valid,
    axi_master_rd_if.master      m_axi
);

    localparam logic [2:0] AR_SIZE = 3'($clog2(AXI_WIDTH / 8));

    rd_state_e            state_q, state_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [AXI_WIDTH-1:0] data_q, data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 beat;
    logic                 cnt_at_len;

    assign beat       = (state_q == ST_DATA) && m_axi.rvalid;
    assign cnt_at_len = (cnt_q == len_q);

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        len_d        = len_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_start) begin
                    addr_d  = rd_addr;
                    len_d   = rd_len;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (m_axi.arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (beat) begin
                    cnt_d        = cnt_q + 1'b1;
                    data_d       = m_axi.rdata;
                    data_valid_d = 1'b1;
                    // Early rlast and missing rlast both flag, but either one ends the burst
                    if ((m_axi.rresp != AXI_RESP_OKAY) || (m_axi.rlast != cnt_at_len)) begin
                        err_d = 1'b1;
                    end
                    if (m_axi.rlast || cnt_at_len) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign rd_busy       = (state_q != ST_IDLE);
    assign rd_done       = (state_q == ST_DONE);
    assign rd_err        = err_q;
    assign rd_data       = data_q;
    assign rd_data_valid = data_valid_q;

    assign m_axi.arid    = AXI_ID;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = AR_SIZE;
    assign m_axi.arburst = AXI_BURST_INCR;
    assign m_axi.arvalid = (state_q == ST_ADDR);
    assign m_axi.rready  = (state_q == ST_DATA);

endmodule

// File: tb/tb_axi_master_rd.sv
// tb/tb_axi_master_rd.sv - randomized self-checking bench for axi_master_rd against a burst-level model
module tb_axi_master_rd;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_start = 1'b0;
    logic [29:0] rd_addr = '0;
    logic [7:0]  rd_len = '0;
    logic        rd_busy;
    logic        rd_done;
    logic        rd_err;
    logic [63:0] rd_data;
    logic        rd_data_valid;

    int n_chk = 0;
    int n_err = 0;

    logic [63:0] got_q[$];

    axi_master_rd_if #(.AXI_WIDTH(64)) axi ();

    axi_master_rd #(.AXI_WIDTH(64), .AXI_ID(4'b0000)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rd_start      (rd_start),
        .rd_addr       (rd_addr),
        .rd_len        (rd_len),
        .rd_busy       (rd_busy),
        .rd_done       (rd_done),
        .rd_err        (rd_err),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .m_axi         (axi)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rd_data_valid) got_q.push_back(rd_data);
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // last_at < 0: rlast on the final beat; last_at > len: rlast never sent.
    // Caller positions time at a negedge; start is driven immediately.
    task automatic run_burst(input logic [29:0] addr, input logic [7:0] len, input int last_at,
                             input int bad_at, input int gap_pct, input int ar_wait, input bit poke);
        logic [63:0] exp_data[$];
        int          last_eff;
        int          n_exp;
        bit          err_exp;
        int          base;
        int          i;
        int          cyc;
        last_eff = (last_at < 0) ? int'(len) : last_at;
        n_exp    = ((last_eff < int'(len)) ? last_eff : int'(len)) + 1;
        err_exp  = (bad_at >= 0 && bad_at < n_exp) || (last_eff != int'(len));
        for (int k = 0; k < n_exp; k++) exp_data.push_back({$urandom, $urandom});

        rd_start = 1'b1; rd_addr = addr; rd_len = len;
        @(negedge clk);
        rd_start = 1'b0;
        base = got_q.size();
        check("start_arvalid", axi.arvalid, 1);
        check("start_busy", rd_busy, 1);
        check("start_err_clear", rd_err, 0);
        check("araddr", axi.araddr, addr);
        check("arlen", axi.arlen, len);
        check("arsize", axi.arsize, 3);
        check("arburst", axi.arburst, 2'b01);
        check("arid", axi.arid, 0);

        for (int w = 0; w < ar_wait; w++) begin
            axi.arready = 1'b0;
            axi.rvalid  = 1'b1;
            axi.rdata   = 64'hdead_beef_dead_beef;
            if (poke && w == 0) begin
                rd_start = 1'b1; rd_addr = ~addr; rd_len = ~len;
            end
            @(negedge clk);
            rd_start = 1'b0;
            check("ar_hold_addr", axi.araddr, addr);
            check("ar_hold_len", axi.arlen, len);
            check("ar_hold_rready", axi.rready, 0);
            check("ar_hold_arvalid", axi.arvalid, 1);
        end
        axi.arready = 1'b1;
        axi.rvalid  = 1'b1;
        axi.rdata   = 64'hbad0_bad0_bad0_bad0;
        @(negedge clk);
        axi.arready = 1'b0;
        check("rready_after_ar", axi.rready, 1);
        check("arvalid_after_ar", axi.arvalid, 0);

        i = 0;
        cyc = 0;
        while (i < n_exp && cyc < 400) begin
            if ($urandom_range(99) < gap_pct) begin
                axi.rvalid = 1'b0;
            end else begin
                check("rready_beat", axi.rready, 1);
                axi.rvalid = 1'b1;
                axi.rdata  = exp_data[i];
                axi.rresp  = (i == bad_at) ? 2'b10 : 2'b00;
                axi.rlast  = (i == last_eff);
                i++;
            end
            rd_start = poke && (cyc == 0);
            @(negedge clk);
            rd_start = 1'b0;
            cyc++;
        end
        axi.rvalid = 1'b0; axi.rlast = 1'b0; axi.rresp = 2'b00;
        if (cyc >= 400) check("data_timeout", 1, 0);

        check("done_pulse", rd_done, 1);
        check("done_last_valid", rd_data_valid, 1);
        check("done_rready_low", axi.rready, 0);
        check("done_busy", rd_busy, 1);
        check("rd_err", rd_err, err_exp);
        @(negedge clk);
        check("idle_busy", rd_busy, 0);
        check("idle_done", rd_done, 0);
        check("idle_valid", rd_data_valid, 0);
        check("data_hold", rd_data, exp_data[n_exp-1]);
        #1;
        check("beat_count", got_q.size() - base, n_exp);
        for (int k = 0; k < n_exp && (base + k) < got_q.size(); k++)
            check("beat_data", got_q[base+k], exp_data[k]);
    endtask

    initial begin
        axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0;
        axi.rresp = 2'b00; axi.rlast = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_busy", rd_busy, 0);
        check("rst_done", rd_done, 0);
        check("rst_err", rd_err, 0);
        check("rst_valid", rd_data_valid, 0);
        check("rst_data", rd_data, 0);
        check("rst_araddr", axi.araddr, 0);
        check("rst_arlen", axi.arlen, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_burst(30'h0000100, 8'd7, -1, -1, 0, 0, 0);
        @(negedge clk);
        run_burst(30'h0abcde0, 8'd3, -1, -1, 20, 5, 0);
        @(negedge clk);
        run_burst(30'h1234560, 8'd15, -1, -1, 40, 1, 0);
        @(negedge clk);
        run_burst(30'h0000200, 8'd7, -1, 3, 0, 0, 0);
        @(negedge clk);
        run_burst(30'h0000300, 8'd7, 2, -1, 0, 0, 0);
        @(negedge clk);
        run_burst(30'h0000400, 8'd4, 999, -1, 10, 0, 0);
        @(negedge clk);
        run_burst(30'h0000500, 8'd5, -1, -1, 0, 2, 1);
        run_burst(30'h0000600, 8'd2, -1, -1, 0, 0, 0);
        run_burst(30'h0000700, 8'd0, -1, -1, 0, 0, 0);

        for (int r = 0; r < 8; r++) begin
            logic [7:0] len;
            int         mode;
            int         last_at;
            int         bad_at;
            len     = 8'($urandom_range(0, 20));
            mode    = $urandom_range(0, 3);
            last_at = -1;
            bad_at  = -1;
            if (mode == 1) bad_at = $urandom_range(0, int'(len));
            if (mode == 2 && len > 0) last_at = $urandom_range(0, int'(len) - 1);
            if (mode == 3) last_at = 999;
            run_burst(30'($urandom), len, last_at, bad_at, $urandom_range(0, 50),
                      $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        @(negedge clk);
        rd_start = 1'b1; rd_addr = 30'h0000800; rd_len = 8'd7;
        @(negedge clk);
        rd_start = 1'b0; axi.arready = 1'b1;
        @(negedge clk);
        axi.arready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            axi.rvalid = 1'b1; axi.rdata = {$urandom, $urandom}; axi.rlast = 1'b0;
            @(negedge clk);
        end
        axi.rvalid = 1'b0;
        check("pre_rst_valid", rd_data_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", rd_busy, 0);
        check("mid_rst_rready", axi.rready, 0);
        check("mid_rst_arvalid", axi.arvalid, 0);
        check("mid_rst_done", rd_done, 0);
        check("mid_rst_err", rd_err, 0);
        check("mid_rst_valid", rd_data_valid, 0);
        check("mid_rst_data", rd_data, 0);
        check("mid_rst_araddr", axi.araddr, 0);
        check("mid_rst_arlen", axi.arlen, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_busy", rd_busy, 0);
        run_burst(30'h0000900, 8'd3, -1, -1, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
